// File: rtl/comparator_6bit.sv
// comparator_6bit: registered magnitude comparator for two WIDTH-bit operands.
// The compare is an MSB-first cascade of per-bit greater/equal terms. In signed
// mode the MSB "greater" term is swapped, because a set sign bit marks the
// smaller value. Result flags and out_valid are registered, so latency is one cycle.
//
// Valid semantics (there is no ready, so the block never stalls): a, b and
// signed_mode are consumed on every rising clk where rst_n=1 and in_valid=1.
// out_valid is in_valid delayed by one cycle. eq/gt/lt keep their last
// qualified result while in_valid=0. Reset clears all four outputs and drops
// any pair presented in the same cycle.
module comparator_6bit #(
  parameter int WIDTH     = 6,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             signed_mode,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             out_valid
);

  // signed_mode has no effect when signed support is compiled out
  logic signed_eff;
  assign signed_eff = SIGNED_EN & signed_mode;

  // Per-bit terms: bit_gt[i] means a wins at bit i; bit_eq[i] means the bits match
  logic [WIDTH-1:0] bit_gt;
  logic [WIDTH-1:0] bit_eq;

  // Cascade chain. Index WIDTH is the seed above the MSB, and index 0 holds the final result.
  logic [WIDTH:0] gt_chain;
  logic [WIDTH:0] eq_chain;

  assign gt_chain[WIDTH] = 1'b0;
  assign eq_chain[WIDTH] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == WIDTH - 1) begin : g_msb
      // Sign bit: in two's complement, a 0 beats a 1
      assign bit_gt[i] = signed_eff ? (~a[i] & b[i]) : (a[i] & ~b[i]);
    end else begin : g_low
      assign bit_gt[i] = a[i] & ~b[i];
    end
    assign bit_eq[i] = ~(a[i] ^ b[i]);

    // a is greater once all higher bits match and this bit favours a
    assign gt_chain[i] = gt_chain[i+1] | (eq_chain[i+1] & bit_gt[i]);
    assign eq_chain[i] = eq_chain[i+1] & bit_eq[i];
  end

  logic cmp_eq;
  logic cmp_gt;
  logic cmp_lt;

  assign cmp_eq = eq_chain[0];
  assign cmp_gt = gt_chain[0];
  assign cmp_lt = ~cmp_eq & ~cmp_gt;

  // Output register: reset clears everything, a qualified pair loads the flags, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        eq <= cmp_eq;
        gt <= cmp_gt;
        lt <= cmp_lt;
      end
    end
  end

endmodule

// File: tb/tb_comparator_6bit.sv
// Testbench for comparator_6bit. It runs directed steps plus random traffic
// and checks every output against an arithmetic reference model.
module tb_comparator_6bit;

  localparam int W = 6;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic         signed_mode;
  logic         eq;
  logic         gt;
  logic         lt;
  logic         out_valid;

  always #5 clk = ~clk;

  comparator_6bit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .signed_mode (signed_mode),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt),
    .out_valid   (out_valid)
  );

  int checks = 0;
  int passed = 0;

  // Reference state: {out_valid, eq, gt, lt} predicted after each edge
  logic [3:0]   exp_q[$];
  logic [3:0]   model_state;

  // ---------------- reference model ----------------
  // The operands are read as plain integers, and the flags come from integer relations.
  function automatic int to_int(input logic [W-1:0] v, input logic sm);
    int u;
    u = int'(v);
    if (sm && u >= (1 << (W - 1))) return u - (1 << W);
    return u;
  endfunction

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sm);
    int vx, vy;
    vx = to_int(x, sm);
    vy = to_int(y, sm);
    return {vx == vy, vx > vy, vx < vy};
  endfunction

  // Predicts the output register contents after one rising edge with the current inputs
  task automatic model_step();
    if (!rst_n) model_state = 4'b0000;
    else if (in_valid) model_state = {1'b1, ref_cmp(a, b, signed_mode)};
    else model_state = {1'b0, model_state[2:0]};
    exp_q.push_back(model_state);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic sm,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    rst_n = r; in_valid = v; signed_mode = sm; a = x; b = y;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    logic [3:0] mdl;
    obs = {out_valid, eq, gt, lt};
    mdl = exp_q.pop_front();
    checks++;
    assert (obs === exp && obs === mdl) passed++;
    else $error("FAIL %s observed=%b expected=%b model=%b", tag, obs, exp, mdl);
  endtask

  task automatic check_model(input string tag);
    logic [3:0] obs;
    logic [3:0] mdl;
    obs = {out_valid, eq, gt, lt};
    mdl = exp_q.pop_front();
    checks++;
    assert (obs === mdl) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, mdl);
  endtask

  task automatic check_onehot(input string tag);
    checks++;
    assert ($countones({eq, gt, lt}) == 1) passed++;
    else $error("FAIL %s observed=%b expected=one-hot", tag, {eq, gt, lt});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_state = 4'b0000;
    drive(1'b0, 1'b1, 1'b0, 6'd9, 6'd9);

    // Reset held for two cycles while in_valid is high
    tick(); check("reset_c1", 4'b0000);
    tick(); check("reset_c2", 4'b0000);

    // After release, outputs stay zero until the first qualified sample
    drive(1'b1, 1'b0, 1'b0, 6'd5, 6'd1);
    tick(); check("post_reset_idle1", 4'b0000);
    tick(); check("post_reset_idle2", 4'b0000);

    // Exhaustive sweeps, back-to-back, one pair per cycle
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < (1 << W); i++) begin
        for (int j = 0; j < (1 << W); j++) begin
          drive(1'b1, 1'b1, m[0], i[W-1:0], j[W-1:0]);
          tick();
          check(m == 0 ? "sweep_unsigned" : "sweep_signed",
                {1'b1, ref_cmp(i[W-1:0], j[W-1:0], m[0])});
          check_onehot("sweep_onehot");
        end
      end
    end

    // -1 < +1 in signed mode
    drive(1'b1, 1'b1, 1'b1, 6'b111111, 6'b000001);
    tick(); check("signed_m1_lt_p1", 4'b1001);

    // Boundary values in both modes
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);   tick(); check("zero_eq_u", 4'b1100);
    drive(1'b1, 1'b1, 1'b1, 6'd0, 6'd0);   tick(); check("zero_eq_s", 4'b1100);
    drive(1'b1, 1'b1, 1'b0, 6'd63, 6'd0);  tick(); check("ones_vs_0_u", 4'b1010);
    drive(1'b1, 1'b1, 1'b1, 6'd63, 6'd0);  tick(); check("ones_vs_0_s", 4'b1001);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd63);  tick(); check("0_vs_ones_u", 4'b1001);
    drive(1'b1, 1'b1, 1'b1, 6'd0, 6'd63);  tick(); check("0_vs_ones_s", 4'b1010);
    drive(1'b1, 1'b1, 1'b1, 6'b100000, 6'b011111); tick(); check("min_lt_max_s", 4'b1001);

    // Hold: flags keep the last qualified result while a/b toggle unqualified
    drive(1'b1, 1'b1, 1'b0, 6'd5, 6'd3);
    tick(); check("hold_load", 4'b1010);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, k[0], 6'($urandom), 6'($urandom));
      tick(); check("hold_keep", 4'b0010);
    end

    // Reset mid-stream discards the pair sampled in that cycle
    drive(1'b0, 1'b1, 1'b0, 6'd9, 6'd9);
    tick(); check("midreset_clear", 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 6'd2, 6'd7);
    tick(); check("midreset_first", 4'b1001);

    // Per-cycle mode toggle on 100000 vs 000000
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, k[0], 6'b100000, 6'b000000);
      tick(); check("mode_toggle", k[0] ? 4'b1001 : 4'b1010);
    end

    // Random traffic with sporadic reset and idle cycles
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
            6'($urandom), 6'($urandom));
      tick(); check_model("random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
